// File: rtl/vx_mem_tag_remap_pkg.sv
// Shared definitions for the memory tag remapper: request kinds, default sizing and
// the transaction-ID width helper.
package vx_mem_tag_remap_pkg;

  localparam int unsigned DefAddrWidth  = 26;
  localparam int unsigned DefLineSize   = 64;
  localparam int unsigned DefTagInWidth = 12;
  localparam int unsigned DefNumIds     = 8;

  typedef enum logic {
    ReqRead  = 1'b0,
    ReqWrite = 1'b1
  } req_kind_e;

  // Memory-side ID width for a pool of n IDs (n is a power of two, >= 2).
  function automatic int unsigned calc_id_width(input int unsigned n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/vx_id_pool.sv
// Free pool of transaction IDs: lowest-free allocation, release by ID and a count of
// IDs currently in flight.
module vx_id_pool
  import vx_mem_tag_remap_pkg::*;
#(
  parameter int unsigned NUM_IDS  = DefNumIds,
  parameter int unsigned ID_WIDTH = calc_id_width(NUM_IDS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_alloc,
  input  logic                i_release,
  input  logic [ID_WIDTH-1:0] i_release_id,
  output logic [ID_WIDTH-1:0] o_alloc_id,
  output logic                o_empty,
  output logic [ID_WIDTH:0]   o_count,
  output logic [NUM_IDS-1:0]  o_free_mask
);

  logic [NUM_IDS-1:0]  r_free_mask;
  logic [NUM_IDS-1:0]  w_free_mask_d;
  logic [ID_WIDTH:0]   r_count;
  logic [ID_WIDTH:0]   w_count_d;
  logic [ID_WIDTH-1:0] w_alloc_id;

  // Scan from the top so the lowest set bit wins.
  always_comb begin
    w_alloc_id = '0;
    for (int i = NUM_IDS - 1; i >= 0; i--) begin
      if (r_free_mask[i]) w_alloc_id = i[ID_WIDTH-1:0];
    end
  end

  // A released ID is busy in r_free_mask, so it never collides with the allocated one.
  always_comb begin
    w_free_mask_d = r_free_mask;
    if (i_alloc)   w_free_mask_d[w_alloc_id]   = 1'b0;
    if (i_release) w_free_mask_d[i_release_id] = 1'b1;
  end

  always_comb begin
    w_count_d = r_count;
    case ({i_alloc, i_release})
      2'b10:   w_count_d = r_count + 1'b1;
      2'b01:   w_count_d = r_count - 1'b1;
      default: w_count_d = r_count;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_free_mask <= '1;
      r_count     <= '0;
    end else begin
      r_free_mask <= w_free_mask_d;
      r_count     <= w_count_d;
    end
  end

  assign o_alloc_id  = w_alloc_id;
  assign o_empty     = (r_free_mask == '0);
  assign o_count     = r_count;
  assign o_free_mask = r_free_mask;

  a_release_busy_id: assert property (@(posedge clk) disable iff (!reset)
    i_release |-> !r_free_mask[i_release_id]);

  a_count_overflow: assert property (@(posedge clk) disable iff (!reset)
    (i_alloc && !i_release) |-> (r_count < (ID_WIDTH + 1)'(NUM_IDS)));

  a_count_underflow: assert property (@(posedge clk) disable iff (!reset)
    (i_release && !i_alloc) |-> (r_count != '0));

endmodule

// File: rtl/vx_mem_tag_remap.sv
// Swaps the wide cache memory tag for a small pooled transaction ID on reads and
// restores the original tag on the matching response.
module vx_mem_tag_remap
  import vx_mem_tag_remap_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = DefAddrWidth,
  parameter int unsigned LINE_SIZE    = DefLineSize,
  parameter int unsigned TAG_IN_WIDTH = DefTagInWidth,
  parameter int unsigned NUM_IDS      = DefNumIds,
  localparam int unsigned ID_WIDTH    = calc_id_width(NUM_IDS),
  localparam int unsigned DATA_WIDTH  = 8 * LINE_SIZE
) (
  input  logic                    clk,
  input  logic                    reset,

  input  logic                    in_req_valid,
  input  logic                    in_req_rw,
  input  logic [ADDR_WIDTH-1:0]   in_req_addr,
  input  logic [LINE_SIZE-1:0]    in_req_byteen,
  input  logic [DATA_WIDTH-1:0]   in_req_data,
  input  logic [TAG_IN_WIDTH-1:0] in_req_tag,
  output logic                    in_req_ready,

  output logic                    in_rsp_valid,
  output logic [DATA_WIDTH-1:0]   in_rsp_data,
  output logic [TAG_IN_WIDTH-1:0] in_rsp_tag,
  input  logic                    in_rsp_ready,

  output logic                    out_req_valid,
  output logic                    out_req_rw,
  output logic [ADDR_WIDTH-1:0]   out_req_addr,
  output logic [LINE_SIZE-1:0]    out_req_byteen,
  output logic [DATA_WIDTH-1:0]   out_req_data,
  output logic [ID_WIDTH-1:0]     out_req_tag,
  input  logic                    out_req_ready,

  input  logic                    out_rsp_valid,
  input  logic [DATA_WIDTH-1:0]   out_rsp_data,
  input  logic [ID_WIDTH-1:0]     out_rsp_tag,
  output logic                    out_rsp_ready,

  output logic [ID_WIDTH:0]       pending_count,
  output logic                    idle
);

  logic                    w_is_write;
  logic                    w_can_issue;
  logic                    w_rd_fire;
  logic                    w_rsp_fire;
  logic [ID_WIDTH-1:0]     w_alloc_id;
  logic                    w_empty;
  logic [ID_WIDTH:0]       w_count;
  logic [NUM_IDS-1:0]      w_free_mask;
  logic [TAG_IN_WIDTH-1:0] r_tag_table [NUM_IDS];

  assign w_is_write  = (req_kind_e'(in_req_rw) == ReqWrite);
  // Writes never consume an ID, so only reads are gated by an empty pool.
  assign w_can_issue = w_is_write || !w_empty;

  assign out_req_valid  = in_req_valid && w_can_issue;
  assign in_req_ready   = out_req_ready && w_can_issue;
  assign out_req_rw     = in_req_rw;
  assign out_req_addr   = in_req_addr;
  assign out_req_byteen = in_req_byteen;
  assign out_req_data   = in_req_data;
  assign out_req_tag    = w_is_write ? '0 : w_alloc_id;

  assign w_rd_fire  = in_req_valid && in_req_ready && !w_is_write;
  assign w_rsp_fire = out_rsp_valid && in_rsp_ready;

  assign in_rsp_valid  = out_rsp_valid;
  assign in_rsp_data   = out_rsp_data;
  assign in_rsp_tag    = r_tag_table[out_rsp_tag];
  assign out_rsp_ready = in_rsp_ready;

  // Contents are meaningful only for busy IDs, so the table needs no reset.
  always_ff @(posedge clk) begin
    if (w_rd_fire) r_tag_table[w_alloc_id] <= in_req_tag;
  end

  vx_id_pool #(
    .NUM_IDS  (NUM_IDS),
    .ID_WIDTH (ID_WIDTH)
  ) u_id_pool (
    .clk          (clk),
    .reset        (reset),
    .i_alloc      (w_rd_fire),
    .i_release    (w_rsp_fire),
    .i_release_id (out_rsp_tag),
    .o_alloc_id   (w_alloc_id),
    .o_empty      (w_empty),
    .o_count      (w_count),
    .o_free_mask  (w_free_mask)
  );

  assign pending_count = w_count;
  assign idle          = (w_count == '0);

  a_req_stable: assert property (@(posedge clk) disable iff (!reset)
    ($past(in_req_valid && !in_req_ready) && in_req_valid) |->
      $stable({in_req_rw, in_req_addr, in_req_byteen, in_req_data, in_req_tag}));

endmodule
